// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a 2-entry skid buffer and RAW hazard tracking.
// Optional perf counters (perf_decoded, perf_stall) are enabled by defining DECODE_PERF_CNT_EN.
module decode_stage #(
  parameter int unsigned IW      = 32,
  parameter int unsigned OPW     = 6,
  parameter int unsigned RW      = 3,
  parameter int unsigned IMMW    = 8,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_OPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   out_alu_op,
  output logic [RW-1:0]    out_rd,
  output logic [RW-1:0]    out_rs1,
  output logic [RW-1:0]    out_rs2,
  output logic [IMMW-1:0]  out_i1,
  output logic [IMMW-1:0]  out_i2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
`ifdef DECODE_PERF_CNT_EN
  output logic [31:0]      perf_decoded,
  output logic [31:0]      perf_stall,
`endif
  output logic             out_raw_hazard
);

  localparam int unsigned RdLsb  = IW - OPW - 1 - RW;
  localparam int unsigned Rs1Lsb = RdLsb - RW;
  localparam int unsigned Rs2Lsb = Rs1Lsb - RW;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [RW-1:0]   rd;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [IMMW-1:0] i1;
    logic [IMMW-1:0] i2;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            hazard;
  } payload_t;

  payload_t        main_q, main_d, skid_q, skid_d, dec;
  logic            m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [RW-1:0]   last_rd_q, last_rd_d;
  logic            last_wr_q, last_wr_d;
  logic            mode;
  logic [XLEN-1:0] sext, zext;
  logic            accept, out_fire;

  always_comb begin
    dec         = '0;
    dec.op      = in_instr[IW-1 -: OPW];
    mode        = in_instr[IW-OPW-1];
    dec.rd      = in_instr[RdLsb +: RW];
    dec.rs1     = in_instr[Rs1Lsb +: RW];
    dec.rs2     = in_instr[Rs2Lsb +: RW];
    dec.i1      = in_instr[IMMW +: IMMW];
    dec.i2      = in_instr[0 +: IMMW];
    sext        = {XLEN{dec.i1[IMMW-1]}};
    sext[2*IMMW-1:0] = {dec.i1, dec.i2};
    zext        = '0;
    zext[IMMW-1:0] = dec.i2;
    dec.imm     = mode ? sext : zext;
    dec.illegal = (32'(dec.op) >= NUM_OPS);
    // Compared against the tracker before this instruction updates it.
    dec.hazard  = last_wr_q & ((dec.rs1 == last_rd_q) | (dec.rs2 == last_rd_q));
  end

  assign in_ready = ~s_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    main_d    = main_q;
    skid_d    = skid_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    last_rd_d = last_rd_q;
    last_wr_d = last_wr_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      last_wr_d = 1'b0;
    end else begin
      if (accept) begin
        last_rd_d = dec.rd;
        last_wr_d = (dec.rd != '0);
      end
      // No input can be accepted while the skid is full, so draining it needs no merge.
      if (s_valid_q && out_ready) begin
        main_d    = skid_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept && (!m_valid_q || out_ready)) begin
        main_d    = dec;
        m_valid_d = 1'b1;
      end else if (accept) begin
        skid_d    = dec;
        s_valid_d = 1'b1;
      end else if (out_fire) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q    <= '0;
      skid_q    <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      last_rd_q <= '0;
      last_wr_q <= 1'b0;
    end else begin
      main_q    <= main_d;
      skid_q    <= skid_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      last_rd_q <= last_rd_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign out_valid      = m_valid_q;
  assign out_alu_op     = main_q.op;
  assign out_rd         = main_q.rd;
  assign out_rs1        = main_q.rs1;
  assign out_rs2        = main_q.rs2;
  assign out_i1         = main_q.i1;
  assign out_i2         = main_q.i2;
  assign out_imm        = main_q.imm;
  assign out_illegal    = main_q.illegal;
  assign out_raw_hazard = main_q.hazard;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded_q, perf_decoded_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_decoded_d = perf_decoded_q;
    perf_stall_d   = perf_stall_q;
    if (out_fire) perf_decoded_d = perf_decoded_q + 32'd1;
    if (m_valid_q && !out_ready) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
